wb_bram_slave: RTL and testbench
================================

Name: wb_bram_slave

Overview:
Wishbone classic slave that maps a parametrised single-port byte-writable RAM into a fixed user address window, with independent read and write wait-state latencies.
Generalises the fixed-delay BRAM slave in the following ways:
- parametrised depth and latencies
- byte-lane writes from wbs_sel_i
- cycle-abort handling
- out-of-range detection with a sticky interrupt
- a transaction counter
Sits in the user project area directly on the Wishbone MI A bus.

Parameters:
BASE_HI, 12'h380, required value of wbs_adr_i[31:20] for a hit
DEPTH_WORDS, 1024, number of 32-bit RAM words (power of two, 16..4096)
RD_DELAY, 10, cycles from request acceptance to read ack (1..255)
WR_DELAY, 10, cycles from request acceptance to write ack (1..255)
CNT_W, 16, width of transaction counter

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  1 = write
wbs_sel_i  in  4  byte lane enables, bit i = byte i
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address; word index = wbs_adr_i[$clog2(DEPTH_WORDS)+1:2]
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  32  read data, valid only while wbs_ack_o = 1
irq_o  out  1  sticky out-of-range error flag
irq_clr_i  in  1  synchronous clear of irq_o
txn_cnt_o  out  CNT_W  count of acknowledged transactions

Behaviour:
- Reset: one clock (wb_clk_i); reset is asynchronous and active-low (wb_rst_ni). Assertion forces the following immediately:
  - state IDLE
  - wbs_ack_o = 0, wbs_dat_o = 0
  - irq_o = 0, txn_cnt_o = 0
  - wait counter = 0
  - RAM contents are not reset.
- Hit: hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE_HI). Non-hits are ignored completely; no ack is generated.
- In range: in_range = (wbs_adr_i[19:2] < DEPTH_WORDS).
- FSM IDLE:
  - On hit in cycle N, latch LAT (WR_DELAY if wbs_we_i else RD_DELAY).
  - LAT = 1 goes directly to ACK (wbs_ack_o high in N+1).
  - Otherwise go to WAIT with counter = LAT-2.
- FSM WAIT:
  - If cyc or stb drops, abort: go to IDLE, no write, no ack, counter not incremented.
  - Else if counter = 0, go to ACK.
  - Else decrement the counter.
- FSM ACK: wbs_ack_o = 1 for exactly one cycle, then IDLE.
- Ack timing: for an unaborted request accepted in cycle N, wbs_ack_o is high in cycle N+LAT only.
- Back-to-back: a new hit is accepted no earlier than the cycle after ACK, i.e. at least one IDLE cycle between acks.
- Write commit:
  - The RAM write happens on the clock edge that enters ACK.
  - Bytes written = those with wbs_sel_i bit set; unselected bytes are unchanged.
  - wbs_sel_i = 4'b0000 writes nothing but still acks.
- Read data:
  - RAM is read at the word index; data is registered on the edge entering ACK and driven on wbs_dat_o during ACK.
  - wbs_dat_o = 0 in all other cycles.
  - Read-after-write to the same word returns the new data.
- Out-of-range hit:
  - Completes with normal latency and ack; no RAM access; read returns 32'h0.
  - irq_o is set on the edge entering ACK.
  - irq_clr_i clears irq_o; simultaneous set and clear → set wins.
- txn_cnt_o: increments on every ack, including out-of-range acks; wraps from all-ones to 0; aborted requests do not count.
- Address, data, we and sel are sampled at acceptance and held internally; changes by the master during WAIT are ignored.
- Reset asserted mid-transaction: transaction abandoned, no write, no ack.

Decomposition:
- Package wb_bram_pkg:
  - FSM state enum {IDLE, WAIT, ACK}
  - BASE_HI default
  - DATA_W = 32, SEL_W = 4
  - LAT_W = 8 counter width
- Sub-module wb_bram_mem: single-port RAM, DEPTH_WORDS x 32, 4 byte-write enables, synchronous write and synchronous registered read, no reset.

Test Plan:
1. Write 0xA5A5_1234 to 0x3800_0010 with sel = 4'hF, then read back → write ack exactly 10 cycles after acceptance; read ack 10 cycles later; wbs_dat_o = 0xA5A5_1234; txn_cnt_o = 2.
2. Byte lanes: preload 0xFFFF_FFFF at 0x3800_0020, write 0x1122_3344 with sel = 4'b0101 → read returns 0xFF22_FF44.
3. Abort: start a write to 0x3800_0030, drop cyc after 4 cycles → no ack ever, word unchanged, txn_cnt_o unchanged; next request accepted normally.
4. Out-of-range, DEPTH_WORDS = 1024: read 0x3800_1000 → ack after RD_DELAY, data 0, irq_o = 1. Pulse irq_clr_i → irq_o = 0. Clear and a new error in the same cycle → irq_o stays 1.
5. Latency params: RD_DELAY = 1, WR_DELAY = 3 → read ack at N+1, write ack at N+3. Address 0x3900_0000 → never acked. Counter wrap: CNT_W = 4, 16 transactions → txn_cnt_o = 0.
6. Async reset: assert wb_rst_ni low mid-WAIT of a write → ack drops immediately, no RAM write; after release, state IDLE and txn_cnt_o = 0.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone BRAM slave.
// Holds the FSM encoding, bus widths and the wait-state latency selector.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [11:0] BASE_HI_DEF = 12'h380;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int LAT_W  = 8;

  function automatic logic [LAT_W-1:0] pick_lat(input logic           we,
                                                input logic [LAT_W-1:0] rd_lat,
                                                input logic [LAT_W-1:0] wr_lat);
    return we ? wr_lat : rd_lat;
  endfunction

endpackage

// File: rtl/wb_bram_mem.sv
// Single-port byte-writable RAM with a registered read port.
// Contents are deliberately not reset.
module wb_bram_mem
  import wb_bram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (i_sel[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_bram_slave.sv
// Wishbone classic slave mapping a byte-writable RAM into a fixed address window,
// with separate read/write wait states, cycle abort, sticky range error and a txn counter.
module wb_bram_slave
  import wb_bram_pkg::*;
#(
  parameter logic [11:0] BASE_HI     = BASE_HI_DEF,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_DELAY    = 10,
  parameter int          WR_DELAY    = 10,
  parameter int          CNT_W       = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq_o,
  input  logic              irq_clr_i,
  output logic [CNT_W-1:0]  txn_cnt_o
);

  localparam int               AW        = $clog2(DEPTH_WORDS);
  localparam logic [17:0]      DEPTH_LIM = 18'(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] RD_LAT    = LAT_W'(RD_DELAY);
  localparam logic [LAT_W-1:0] WR_LAT    = LAT_W'(WR_DELAY);

  state_t             r_state, w_state_nxt;
  logic [LAT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [AW-1:0]      r_idx;
  logic [DATA_W-1:0]  r_wdat;
  logic [SEL_W-1:0]   r_sel;
  logic               r_we;
  logic               r_inr;
  logic               r_irq;
  logic [CNT_W-1:0]   r_txn;

  logic               w_hit;
  logic               w_inr;
  logic               w_bus_live;
  logic               w_accept;
  logic               w_go_ack;
  logic [LAT_W-1:0]   w_lat;
  logic               w_in_idle;
  logic               w_eff_we;
  logic               w_eff_inr;
  logic [AW-1:0]      w_eff_idx;
  logic [DATA_W-1:0]  w_eff_dat;
  logic [SEL_W-1:0]   w_eff_sel;
  logic               w_mem_we;
  logic               w_mem_re;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_unused_adr;

  assign w_bus_live   = wbs_cyc_i & wbs_stb_i;
  assign w_hit        = w_bus_live & (wbs_adr_i[31:20] == BASE_HI);
  assign w_inr        = (wbs_adr_i[19:2] < DEPTH_LIM);
  assign w_lat        = pick_lat(wbs_we_i, RD_LAT, WR_LAT);
  assign w_unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_accept    = 1'b0;
    w_go_ack    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_accept = 1'b1;
          if (w_lat == LAT_W'(1)) begin
            w_state_nxt = ACK;
            w_go_ack    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_wcnt_nxt  = w_lat - LAT_W'(2);
          end
        end
      end
      WAIT: begin
        if (!w_bus_live) begin
          w_state_nxt = IDLE;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == '0) begin
          w_state_nxt = ACK;
          w_go_ack    = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt - LAT_W'(1);
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_irq   <= 1'b0;
      r_txn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_go_ack && !w_eff_inr) r_irq <= 1'b1;
      else if (irq_clr_i)         r_irq <= 1'b0;
      if (w_go_ack) r_txn <= r_txn + CNT_W'(1);
    end
  end

  // Request fields are captured at acceptance so master changes during WAIT are ignored.
  always_ff @(posedge wb_clk_i) begin
    if (w_accept) begin
      r_idx  <= wbs_adr_i[AW+1:2];
      r_wdat <= wbs_dat_i;
      r_sel  <= wbs_sel_i;
      r_we   <= wbs_we_i;
      r_inr  <= w_inr;
    end
  end

  // A one-cycle latency commits straight from IDLE, so the live bus is used there.
  assign w_in_idle = (r_state == IDLE);
  assign w_eff_we  = w_in_idle ? wbs_we_i          : r_we;
  assign w_eff_inr = w_in_idle ? w_inr             : r_inr;
  assign w_eff_idx = w_in_idle ? wbs_adr_i[AW+1:2] : r_idx;
  assign w_eff_dat = w_in_idle ? wbs_dat_i         : r_wdat;
  assign w_eff_sel = w_in_idle ? wbs_sel_i         : r_sel;

  assign w_mem_we = w_go_ack & w_eff_we & w_eff_inr & wb_rst_ni;
  assign w_mem_re = w_go_ack & ~w_eff_we & w_eff_inr;

  wb_bram_mem #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .i_clk   (wb_clk_i),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_sel   (w_eff_sel),
    .i_addr  (w_eff_idx),
    .i_wdata (w_eff_dat),
    .o_rdata (w_rdata)
  );

  assign wbs_ack_o = (r_state == ACK);
  assign wbs_dat_o = (r_state == ACK && !r_we && r_inr) ? w_rdata : '0;
  assign irq_o     = r_irq;
  assign txn_cnt_o = r_txn;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Randomised bench for wb_bram_slave: two instances (default latencies, and RD=1/WR=3/CNT_W=4)
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_wb_bram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic        clr [2];
  logic [3:0]  sel [2];
  logic [31:0] dat [2];
  logic [31:0] adr [2];
  logic        ack [2];
  logic        irq [2];
  logic [31:0] q   [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [15:0] cnt_w [2];

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = {12'b0, cnt1};

  wb_bram_slave u_dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]),
    .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_dat_i(dat[0]), .wbs_adr_i(adr[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(q[0]), .irq_o(irq[0]), .irq_clr_i(clr[0]),
    .txn_cnt_o(cnt0)
  );

  wb_bram_slave #(.RD_DELAY(1), .WR_DELAY(3), .CNT_W(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]),
    .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_dat_i(dat[1]), .wbs_adr_i(adr[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(q[1]), .irq_o(irq[1]), .irq_clr_i(clr[1]),
    .txn_cnt_o(cnt1)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int RDL [2]   = '{10, 1};
  int WRL [2]   = '{10, 3};
  int CMASK [2] = '{16'hFFFF, 16'h000F};

  logic [31:0] mm [2][1024];
  bit   [3:0]  mv [2][1024];
  bit          pend [2];
  int          p_acc [2];
  int          p_ackc [2];
  int          last_ack [2];
  bit          p_we [2];
  bit          p_inr [2];
  int          p_idx [2];
  logic [31:0] p_dat [2];
  logic [3:0]  p_sel [2];
  int          m_cnt [2];
  bit          m_irq [2];

  bit rnd_clr = 1'b0;
  bit man_clr [2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d cycle=%0d got=%h expected=%h", name, k, cyc_n, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int c;
    bit ea;
    logic [31:0] ed, mk;
    c  = cyc_n;
    ea = pend[k] && (p_ackc[k] == c);
    ed = '0;
    mk = '1;
    if (ea && !p_we[k] && p_inr[k]) begin
      ed = mm[k][p_idx[k]];
      for (int b = 0; b < 4; b++) mk[8*b +: 8] = {8{mv[k][p_idx[k]][b]}};
    end
    chk("ack", k, {31'b0, ack[k]}, {31'b0, ea});
    chk("dat", k, q[k] & mk, ed & mk);
    chk("irq", k, {31'b0, irq[k]}, {31'b0, m_irq[k]});
    chk("cnt", k, {16'b0, cnt_w[k]}, m_cnt[k]);

    if (ea) begin
      if (p_we[k] && p_inr[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (p_sel[k][b]) begin
            mm[k][p_idx[k]][8*b +: 8] = p_dat[k][8*b +: 8];
            mv[k][p_idx[k]][b] = 1'b1;
          end
        end
      end
      pend[k] = 1'b0;
      last_ack[k] = c;
    end else if (pend[k] && c > p_acc[k] && !(cyc[k] && stb[k])) begin
      pend[k] = 1'b0;
    end else if (!pend[k] && c != last_ack[k] && cyc[k] && stb[k] && adr[k][31:20] == 12'h380) begin
      pend[k]   = 1'b1;
      p_acc[k]  = c;
      p_ackc[k] = c + (we[k] ? WRL[k] : RDL[k]);
      p_we[k]   = we[k];
      p_inr[k]  = (adr[k][19:2] < 18'd1024);
      p_idx[k]  = int'(adr[k][11:2]);
      p_dat[k]  = dat[k];
      p_sel[k]  = sel[k];
    end

    if (pend[k] && p_ackc[k] == c + 1) begin
      m_cnt[k] = (m_cnt[k] + 1) & CMASK[k];
      if (!p_inr[k])   m_irq[k] = 1'b1;
      else if (clr[k]) m_irq[k] = 1'b0;
    end else if (clr[k]) begin
      m_irq[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("rst_ack", k, {31'b0, ack[k]}, 32'd0);
        chk("rst_dat", k, q[k], 32'd0);
        chk("rst_irq", k, {31'b0, irq[k]}, 32'd0);
        chk("rst_cnt", k, {16'b0, cnt_w[k]}, 32'd0);
        pend[k] = 1'b0;
        m_irq[k] = 1'b0;
        m_cnt[k] = 0;
        last_ack[k] = -1;
      end else begin
        model_step(k);
      end
    end
  end

  initial begin
    forever begin
      for (int k = 0; k < 2; k++) clr[k] = rnd_clr ? ($urandom_range(0, 7) == 0) : man_clr[k];
      @(posedge clk);
      #2;
    end
  end

  task automatic wb_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat, output bit iv);
    int start;
    bit got;
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
    start = cyc_n;
    got = 1'b0;
    rd = '0; lat = -1; iv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack[k]) begin
        got = 1'b1; rd = q[k]; iv = irq[k]; lat = cyc_n - start;
        break;
      end
    end
    if (!got) chk("ack_timeout", k, 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic hold_miss(input int k, input logic [31:0] a, input int n, output int nack);
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = a; sel[k] = 4'hF;
    nack = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack[k]) nack++;
    end
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  task automatic abort_txn(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int h, input bit drop_cyc);
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; dat[k] = d; sel[k] = s;
    for (int i = 0; i < h; i++) @(negedge clk);
    @(posedge clk); #1;
    if (drop_cyc) cyc[k] = 1'b0; else stb[k] = 1'b0;
    dat[k] = ~d;
    @(posedge clk); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog k=0 got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, nack, c, kk, kind, h, idx;
    bit iv, w;
    logic [31:0] a;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 0; dat[k] = 0; adr[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_cnt", 0, {16'b0, cnt_w[0]}, 32'd0);
    chk("init_irq", 0, {31'b0, irq[0]}, 32'd0);

    // Basic write then read-back with default latency
    wb_txn(0, 1, 32'h3800_0010, 32'hA5A5_1234, 4'hF, rd, lat, iv);
    chk("t1_wr_lat", 0, lat, 32'd10);
    wb_txn(0, 0, 32'h3800_0010, 32'h0, 4'hF, rd, lat, iv);
    chk("t1_rd_lat", 0, lat, 32'd10);
    chk("t1_rd_dat", 0, rd, 32'hA5A5_1234);
    chk("t1_cnt", 0, {16'b0, cnt_w[0]}, 32'd2);

    // Byte lanes
    wb_txn(0, 1, 32'h3800_0020, 32'hFFFF_FFFF, 4'hF, rd, lat, iv);
    wb_txn(0, 1, 32'h3800_0020, 32'h1122_3344, 4'b0101, rd, lat, iv);
    wb_txn(0, 0, 32'h3800_0020, 32'h0, 4'hF, rd, lat, iv);
    chk("t2_bytes", 0, rd, 32'hFF22_FF44);
    wb_txn(0, 1, 32'h3800_0020, 32'h5555_5555, 4'b0000, rd, lat, iv);
    wb_txn(0, 0, 32'h3800_0020, 32'h0, 4'hF, rd, lat, iv);
    chk("t2_sel0", 0, rd, 32'hFF22_FF44);

    // Abort mid-wait
    wb_txn(0, 1, 32'h3800_0030, 32'hCAFE_0001, 4'hF, rd, lat, iv);
    c = cnt_w[0];
    abort_txn(0, 32'h3800_0030, 32'hDEAD_BEEF, 4'hF, 4, 1'b1);
    hold_miss(0, 32'h0000_0000, 15, nack);
    chk("t3_no_ack", 0, nack, 32'd0);
    chk("t3_cnt", 0, {16'b0, cnt_w[0]}, c);
    wb_txn(0, 0, 32'h3800_0030, 32'h0, 4'hF, rd, lat, iv);
    chk("t3_lat", 0, lat, 32'd10);
    chk("t3_dat", 0, rd, 32'hCAFE_0001);

    // Out-of-range and sticky irq
    wb_txn(0, 0, 32'h3800_1000, 32'h0, 4'hF, rd, lat, iv);
    chk("t4_lat", 0, lat, 32'd10);
    chk("t4_dat", 0, rd, 32'd0);
    chk("t4_irq", 0, {31'b0, iv}, 32'd1);
    man_clr[0] = 1'b1;
    @(posedge clk); #1 man_clr[0] = 1'b0;
    @(negedge clk);
    chk("t4_clr", 0, {31'b0, irq[0]}, 32'd0);
    @(posedge clk); #1 man_clr[0] = 1'b1;
    wb_txn(0, 1, 32'h3800_2000, 32'h1234_5678, 4'hF, rd, lat, iv);
    chk("t4_set_wins", 0, {31'b0, iv}, 32'd1);
    man_clr[0] = 1'b0;

    // Short latencies, miss, counter wrap
    wb_txn(1, 1, 32'h3800_0040, 32'h0BAD_F00D, 4'hF, rd, lat, iv);
    chk("t5_wr_lat", 1, lat, 32'd3);
    wb_txn(1, 0, 32'h3800_0040, 32'h0, 4'hF, rd, lat, iv);
    chk("t5_rd_lat", 1, lat, 32'd1);
    chk("t5_rd_dat", 1, rd, 32'h0BAD_F00D);
    hold_miss(1, 32'h3900_0000, 20, nack);
    chk("t5_miss1", 1, nack, 32'd0);
    hold_miss(0, 32'h3900_0000, 20, nack);
    chk("t5_miss0", 0, nack, 32'd0);
    c = cnt_w[1];
    for (int i = 0; i < 16; i++) wb_txn(1, i[0], 32'h3800_0044, i, 4'hF, rd, lat, iv);
    chk("t5_wrap", 1, {16'b0, cnt_w[1]}, c);

    // Async reset in the middle of a write
    wb_txn(0, 1, 32'h3800_0050, 32'h1234_5678, 4'hF, rd, lat, iv);
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h3800_0050; dat[0] = 32'h8765_4321; sel[0] = 4'hF;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack", 0, {31'b0, ack[0]}, 32'd0);
    chk("t6_cnt", 0, {16'b0, cnt_w[0]}, 32'd0);
    chk("t6_irq", 0, {31'b0, irq[0]}, 32'd0);
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("t6_cnt_rel", 0, {16'b0, cnt_w[0]}, 32'd0);
    wb_txn(0, 0, 32'h3800_0050, 32'h0, 4'hF, rd, lat, iv);
    chk("t6_dat", 0, rd, 32'h1234_5678);
    chk("t6_lat", 0, lat, 32'd10);

    // Randomised traffic
    rnd_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      kk   = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      w    = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 63);
      a    = 32'h3800_0000 | (32'(idx) << 2);
      if (kind == 7) a = 32'h3800_0000 | (32'($urandom_range(1024, 262143)) << 2);
      if (kind == 8) begin
        a = {12'h381 + 12'($urandom_range(0, 3)), 20'($urandom)};
        hold_miss(kk, a, $urandom_range(3, 12), nack);
        chk("rnd_miss", kk, nack, 32'd0);
      end else if (kind == 9 && (w ? WRL[kk] : RDL[kk]) > 1) begin
        h = $urandom_range(1, (w ? WRL[kk] : RDL[kk]) - 1);
        abort_txn(kk, a, $urandom, 4'($urandom), h, 1'($urandom_range(0, 1)));
      end else begin
        wb_txn(kk, w, a, $urandom, 4'($urandom), rd, lat, iv);
        chk("rnd_lat", kk, lat, w ? WRL[kk] : RDL[kk]);
      end
    end
    rnd_clr = 1'b0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
